// File: rtl/acc.sv
// acc: JVM bytecode -> ARM word translator; program/microcode ROMs are constant tables read in one cycle.
// One word per oram_ready handshake; WAIT holds arm_inst while oram_ready=0. `define WIDE_EN honours the 0xC4 prefix.
module acc #(
  parameter int              SMNL             = 3,
  parameter int              PARAM_LEN        = 2,
  parameter int              adr_rom_adr_size = 8,
  parameter logic [SMNL-1:0] FSTATE           = 3'd7,
  parameter logic [2047:0]   PROG             = 2048'hFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        oram_ready,
  output logic [31:0]                 arm_inst,
  output logic                        valid_write,
  output logic [7:0]                  oram_iter,
  output logic [SMNL-1:0]             state,
  output logic                        waiting,
  output logic [7:0]                  iram,
  output logic                        iram_ready,
  output logic [7:0]                  jvm_opcode,
  output logic [PARAM_LEN-1:0]        parameter_number,
  output logic                        param_even,
  output logic [7:0]                  byte_to_push,
  output logic                        push_wide,
  output logic                        is_wide,
  output logic                        q_select,
  output logic [31:0]                 push_inst,
  output logic [31:0]                 instr,
  output logic [adr_rom_adr_size-1:0] link_list_ptr
);
  localparam int LW = 32 + adr_rom_adr_size + 1;
  typedef logic [adr_rom_adr_size-1:0] ptr_t;
  typedef logic [PARAM_LEN-1:0]        cnt_t;
  typedef enum logic [SMNL-1:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_PARAM = 3'd3,
    S_PUSH = 3'd4, S_EMIT = 3'd5, S_WAIT = 3'd6, S_FINAL = FSTATE
  } state_t;

  function automatic cnt_t cnt_rom(input logic [7:0] op);
    case (op)
      8'h10, 8'h15: cnt_rom = cnt_t'(1);
      8'h11:        cnt_rom = cnt_t'(2);
      default:      cnt_rom = '0;
    endcase
  endfunction

  function automatic ptr_t start_rom(input logic [7:0] op);
    case (op)
      8'h10:   start_rom = ptr_t'(1);
      8'h11:   start_rom = ptr_t'(2);
      8'h15:   start_rom = ptr_t'(5);
      8'hC4:   start_rom = ptr_t'(7);
      default: start_rom = ptr_t'(0);
    endcase
  endfunction

  // Entry layout: {instr, next pointer, last}
  function automatic logic [LW-1:0] list_rom(input ptr_t p);
    case (p)
      ptr_t'(1): list_rom = {32'hE52D_1004, ptr_t'(0), 1'b1};
      ptr_t'(2): list_rom = {32'hE1A0_1401, ptr_t'(3), 1'b0};
      ptr_t'(3): list_rom = {32'hE181_1002, ptr_t'(4), 1'b0};
      ptr_t'(4): list_rom = {32'hE52D_1004, ptr_t'(0), 1'b1};
      ptr_t'(5): list_rom = {32'hE79B_1101, ptr_t'(6), 1'b0};
      ptr_t'(6): list_rom = {32'hE52D_1004, ptr_t'(0), 1'b1};
      ptr_t'(7): list_rom = {32'hE320_F000, ptr_t'(0), 1'b1};
      default:   list_rom = {32'hE1A0_0000, ptr_t'(0), 1'b1};
    endcase
  endfunction

  state_t          state_q, ret_q, nxt_d;
  logic [7:0]      pc_q, iram_q, jvm_opcode_q, byte_q, oram_iter_q;
  logic            iram_ready_q, param_even_q, push_wide_q, is_wide_q, q_select_q;
  logic            valid_write_q, waiting_q, list_vld_q;
  cnt_t            cnt_q, pn_q;
  ptr_t            start_q, ptr_q;
  logic [LW-1:0]   list_q;
  logic [31:0]     push_inst_q, arm_inst_q, push_inst_d, emit_word_d;

  always_comb begin
    push_inst_d = push_wide_q ? 32'hE3A0_3001
                : ((param_even_q ? 32'hE3A0_1000 : 32'hE3A0_2000) | {24'd0, byte_q});
    emit_word_d = (state_q == S_PUSH) ? push_inst_d : list_q[LW-1 -: 32];
    nxt_d = S_EMIT;
    if (state_q == S_PUSH) begin
      if (!push_wide_q && pn_q != cnt_t'(1))  nxt_d = S_PARAM;
      else if (!push_wide_q && is_wide_q)     nxt_d = S_PUSH;
    end else if (list_q[0]) begin
      nxt_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;      ret_q <= S_IDLE;      pc_q <= '0;
      iram_q <= '0;           iram_ready_q <= 1'b0; jvm_opcode_q <= '0;
      cnt_q <= '0;            start_q <= '0;        pn_q <= '0;
      param_even_q <= 1'b0;   byte_q <= '0;         push_wide_q <= 1'b0;
      is_wide_q <= 1'b0;      q_select_q <= 1'b0;   push_inst_q <= '0;
      arm_inst_q <= '0;       valid_write_q <= 1'b0; oram_iter_q <= '0;
      waiting_q <= 1'b0;      ptr_q <= '0;          list_q <= '0;
      list_vld_q <= 1'b0;
    end else begin
      // ROM reads; the *_ready/_vld flags drop for one cycle whenever the address moves
      iram_q        <= PROG[{pc_q, 3'b000} +: 8];
      cnt_q         <= cnt_rom(iram_q);
      start_q       <= start_rom(iram_q);
      list_q        <= list_rom(ptr_q);
      iram_ready_q  <= 1'b1;
      list_vld_q    <= 1'b1;
      valid_write_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: if (iram_ready_q) begin
          if (iram_q == 8'hFF) begin
            state_q <= S_FINAL;
`ifdef WIDE_EN
          end else if (iram_q == 8'hC4) begin
            is_wide_q    <= 1'b1;
            pc_q         <= pc_q + 8'd1;
            iram_ready_q <= 1'b0;
`endif
          end else begin
            jvm_opcode_q <= iram_q;
            pc_q         <= pc_q + 8'd1;
            iram_ready_q <= 1'b0;
            state_q      <= S_DECODE;
          end
        end
        S_DECODE: begin
          pn_q         <= is_wide_q ? cnt_t'(cnt_q << 1) : cnt_q;
          ptr_q        <= start_q;
          list_vld_q   <= 1'b0;
          param_even_q <= 1'b1;
          if (cnt_q != '0) begin
            state_q <= S_PARAM;
          end else if (is_wide_q) begin
            push_wide_q <= 1'b1;
            state_q     <= S_PUSH;
          end else begin
            state_q <= S_EMIT;
          end
        end
        S_PARAM: if (iram_ready_q) begin
          byte_q       <= iram_q;
          pc_q         <= pc_q + 8'd1;
          iram_ready_q <= 1'b0;
          state_q      <= S_PUSH;
        end
        // Side effects happen at the attempt; a stall only defers the write strobe.
        S_PUSH, S_EMIT: if (state_q == S_PUSH || list_vld_q) begin
          arm_inst_q <= emit_word_d;
          ret_q      <= nxt_d;
          if (oram_ready) begin
            valid_write_q <= 1'b1;
            oram_iter_q   <= oram_iter_q + 8'd1;
            state_q       <= nxt_d;
          end else begin
            waiting_q <= 1'b1;
            state_q   <= S_WAIT;
          end
          if (state_q == S_PUSH) begin
            q_select_q  <= 1'b1;
            push_inst_q <= push_inst_d;
            push_wide_q <= !push_wide_q && is_wide_q && (pn_q == cnt_t'(1));
            if (!push_wide_q) begin
              param_even_q <= !param_even_q;
              pn_q         <= pn_q - cnt_t'(1);
            end
          end else begin
            q_select_q <= 1'b0;
            ptr_q      <= list_q[adr_rom_adr_size:1];
            list_vld_q <= 1'b0;
            if (list_q[0]) is_wide_q <= 1'b0;
          end
        end
        S_WAIT: if (oram_ready) begin
          valid_write_q <= 1'b1;
          oram_iter_q   <= oram_iter_q + 8'd1;
          waiting_q     <= 1'b0;
          state_q       <= ret_q;
        end
        S_FINAL: state_q <= S_FINAL;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arm_inst         = arm_inst_q;
  assign valid_write      = valid_write_q;
  assign oram_iter        = oram_iter_q;
  assign state            = state_q;
  assign waiting          = waiting_q;
  assign iram             = iram_q;
  assign iram_ready       = iram_ready_q;
  assign jvm_opcode       = jvm_opcode_q;
  assign parameter_number = pn_q;
  assign param_even       = param_even_q;
  assign byte_to_push     = byte_q;
  assign q_select         = q_select_q;
  assign push_inst        = push_inst_q;
  assign instr            = list_q[LW-1 -: 32];
  assign link_list_ptr    = ptr_q;
`ifdef WIDE_EN
  assign push_wide        = push_wide_q;
  assign is_wide          = is_wide_q;
`else
  assign push_wide        = 1'b0;
  assign is_wide          = 1'b0;
`endif
endmodule

// File: tb/tb_acc.sv
// Directed bench for acc: a translation program and a lone-FF program run side by side.
module tb_acc;
  logic clk = 1'b0, reset = 1'b0, oram_ready = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] arm_inst, push_inst, instr;
  logic        valid_write, waiting, iram_ready, param_even, push_wide, is_wide, q_select;
  logic [7:0]  oram_iter, iram, jvm_opcode, byte_to_push, link_list_ptr;
  logic [2:0]  state;
  logic [1:0]  parameter_number;

  logic [31:0] ff_arm_inst, ff_push_inst, ff_instr;
  logic        ff_valid_write, ff_waiting, ff_iram_ready, ff_param_even, ff_push_wide, ff_is_wide, ff_q_select;
  logic [7:0]  ff_oram_iter, ff_iram, ff_jvm_opcode, ff_byte_to_push, ff_link_list_ptr;
  logic [2:0]  ff_state;
  logic [1:0]  ff_parameter_number;

  // bytes from the right: 10 05 | 11 12 34 | C4 | 15 00 | 07 | FF
  acc #(.PROG(2048'hFF070015C43412110510)) dut (
    .clk(clk), .reset(reset), .oram_ready(oram_ready), .arm_inst(arm_inst), .valid_write(valid_write),
    .oram_iter(oram_iter), .state(state), .waiting(waiting), .iram(iram), .iram_ready(iram_ready),
    .jvm_opcode(jvm_opcode), .parameter_number(parameter_number), .param_even(param_even),
    .byte_to_push(byte_to_push), .push_wide(push_wide), .is_wide(is_wide), .q_select(q_select),
    .push_inst(push_inst), .instr(instr), .link_list_ptr(link_list_ptr));

  acc #(.PROG(2048'hFF)) dut_ff (
    .clk(clk), .reset(reset), .oram_ready(oram_ready), .arm_inst(ff_arm_inst), .valid_write(ff_valid_write),
    .oram_iter(ff_oram_iter), .state(ff_state), .waiting(ff_waiting), .iram(ff_iram), .iram_ready(ff_iram_ready),
    .jvm_opcode(ff_jvm_opcode), .parameter_number(ff_parameter_number), .param_even(ff_param_even),
    .byte_to_push(ff_byte_to_push), .push_wide(ff_push_wide), .is_wide(ff_is_wide), .q_select(ff_q_select),
    .push_inst(ff_push_inst), .instr(ff_instr), .link_list_ptr(ff_link_list_ptr));

  int          nvec = 0, nmis = 0, ff_vw_cnt = 0;
  logic [31:0] cap[$];
  logic [31:0] exp_w [12];
  bit          sink_mode = 1'b0, saw_push_wide = 1'b0, saw_wait = 1'b0;

  task automatic step();
    @(negedge clk);
    if (valid_write === 1'b1) cap.push_back(arm_inst);
    if (ff_valid_write === 1'b1) ff_vw_cnt++;
    if (push_wide === 1'b1) saw_push_wide = 1'b1;
    if (waiting === 1'b1) saw_wait = 1'b1;
    if (sink_mode) oram_ready = !valid_write;
  endtask

  task automatic do_reset();
    reset = 1'b0; oram_ready = 1'b1;
    step(); step();
    reset = 1'b1;
    cap.delete(); saw_push_wide = 1'b0; saw_wait = 1'b0;
  endtask

  task automatic run_to_end(input int budget, output bit ok);
    int t = 0;
    while (state !== 3'd7 && t < budget) begin step(); t++; end
    ok = (state === 3'd7);
  endtask

  task automatic test_reset();
    step(); step();
    nvec++; if (state !== 3'd0)        begin nmis++; $display("FAIL rst_state: got %0d, want 0", state); end
    nvec++; if (arm_inst !== 32'd0)    begin nmis++; $display("FAIL rst_arm_inst: got %h, want 0", arm_inst); end
    nvec++; if (push_inst !== 32'd0)   begin nmis++; $display("FAIL rst_push_inst: got %h, want 0", push_inst); end
    nvec++; if (valid_write !== 1'b0)  begin nmis++; $display("FAIL rst_valid_write: got %b, want 0", valid_write); end
    nvec++; if (oram_iter !== 8'd0)    begin nmis++; $display("FAIL rst_oram_iter: got %0d, want 0", oram_iter); end
    nvec++; if ({iram_ready, waiting, q_select, param_even, is_wide} !== 5'b0)
      begin nmis++; $display("FAIL rst_flags: got %b, want 00000", {iram_ready, waiting, q_select, param_even, is_wide}); end
    nvec++; if (link_list_ptr !== 8'd0 || parameter_number !== 2'd0)
      begin nmis++; $display("FAIL rst_ptr_cnt: ptr=%0d cnt=%0d, want 0/0", link_list_ptr, parameter_number); end
  endtask

  task automatic test_ff();
    int t = 0;
    ff_vw_cnt = 0;
    reset = 1'b1;
    while (ff_state !== 3'd7 && t < 4) begin step(); t++; end
    nvec++; if (ff_state !== 3'd7) begin nmis++; $display("FAIL ff_final: state=%0d after %0d cycles, want 7", ff_state, t); end
    repeat (5) step();
    nvec++; if (ff_state !== 3'd7) begin nmis++; $display("FAIL ff_absorb: state=%0d, want 7", ff_state); end
    nvec++; if (ff_vw_cnt != 0)    begin nmis++; $display("FAIL ff_no_write: %0d writes, want 0", ff_vw_cnt); end
    nvec++; if (ff_oram_iter !== 8'd0) begin nmis++; $display("FAIL ff_iter: got %0d, want 0", ff_oram_iter); end
  endtask

  task automatic test_stream();
    bit ok;
    do_reset();
    run_to_end(400, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL stream_done: state=%0d, want 7", state); end
    nvec++; if (cap.size() != 12) begin nmis++; $display("FAIL stream_len: %0d words, want 12", cap.size()); end
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      nvec++; if (cap[i] !== exp_w[i]) begin nmis++; $display("FAIL stream_word%0d: got %h, want %h", i, cap[i], exp_w[i]); end
    end
    repeat (6) step();
    nvec++; if (cap.size() != 12) begin nmis++; $display("FAIL final_quiet: %0d words, want 12", cap.size()); end
    nvec++; if (oram_iter !== 8'd12) begin nmis++; $display("FAIL stream_iter: got %0d, want 12", oram_iter); end
    nvec++; if (is_wide !== 1'b0)    begin nmis++; $display("FAIL wide_cleared: got %b, want 0", is_wide); end
`ifdef WIDE_EN
    nvec++; if (saw_push_wide !== 1'b1) begin nmis++; $display("FAIL wide_marker: seen %b, want 1", saw_push_wide); end
`else
    nvec++; if (saw_push_wide !== 1'b0) begin nmis++; $display("FAIL wide_marker: seen %b, want 0", saw_push_wide); end
`endif
  endtask

  task automatic test_stall();
    bit ok;
    int t = 0;
    do_reset();
    while (state !== 3'd5 && t < 50) begin step(); t++; end
    nvec++; if (state !== 3'd5) begin nmis++; $display("FAIL stall_reach_emit: state=%0d, want 5", state); end
    oram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++; if (valid_write !== 1'b0) begin nmis++; $display("FAIL stall_no_write: cycle %0d got %b, want 0", i, valid_write); end
      nvec++; if (arm_inst !== 32'hE52D1004) begin nmis++; $display("FAIL stall_hold: cycle %0d got %h, want e52d1004", i, arm_inst); end
    end
    nvec++; if (waiting !== 1'b1) begin nmis++; $display("FAIL stall_waiting: got %b, want 1", waiting); end
    nvec++; if (cap.size() != 1)  begin nmis++; $display("FAIL stall_count: %0d words, want 1", cap.size()); end
    oram_ready = 1'b1;
    run_to_end(400, ok);
    nvec++; if (cap.size() != 12) begin nmis++; $display("FAIL stall_len: %0d words, want 12", cap.size()); end
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      nvec++; if (cap[i] !== exp_w[i]) begin nmis++; $display("FAIL stall_word%0d: got %h, want %h", i, cap[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    do_reset();
    while (state !== 3'd4 && t < 50) begin step(); t++; end
    nvec++; if (state !== 3'd4) begin nmis++; $display("FAIL mid_reach_push: state=%0d, want 4", state); end
    #2 reset = 1'b0;
    #1;
    nvec++; if (state !== 3'd0 || oram_iter !== 8'd0) begin nmis++; $display("FAIL mid_rst_state: state=%0d iter=%0d, want 0/0", state, oram_iter); end
    nvec++; if (arm_inst !== 32'd0 || push_inst !== 32'd0) begin nmis++; $display("FAIL mid_rst_words: arm=%h push=%h, want 0/0", arm_inst, push_inst); end
    nvec++; if ({q_select, byte_to_push, parameter_number} !== 11'd0)
      begin nmis++; $display("FAIL mid_rst_regs: qsel=%b byte=%h cnt=%0d, want 0", q_select, byte_to_push, parameter_number); end
    step();
    reset = 1'b1;
    cap.delete();
    run_to_end(400, ok);
    nvec++; if (cap.size() != 12) begin nmis++; $display("FAIL mid_len: %0d words, want 12", cap.size()); end
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      nvec++; if (cap[i] !== exp_w[i]) begin nmis++; $display("FAIL mid_word%0d: got %h, want %h", i, cap[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    sink_mode = 1'b1;
    run_to_end(600, ok);
    sink_mode = 1'b0; oram_ready = 1'b1;
    nvec++; if (saw_wait !== 1'b1) begin nmis++; $display("FAIL sink_wait_seen: got %b, want 1", saw_wait); end
    nvec++; if (cap.size() != 12) begin nmis++; $display("FAIL sink_len: %0d words, want 12", cap.size()); end
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      nvec++; if (cap[i] !== exp_w[i]) begin nmis++; $display("FAIL sink_word%0d: got %h, want %h", i, cap[i], exp_w[i]); end
    end
    nvec++; if (oram_iter !== 8'd12) begin nmis++; $display("FAIL sink_iter: got %0d, want 12", oram_iter); end
  endtask

  initial begin
`ifdef WIDE_EN
    exp_w = '{32'hE3A01005, 32'hE52D1004, 32'hE3A01012, 32'hE3A02034, 32'hE1A01401, 32'hE1811002,
              32'hE52D1004, 32'hE3A01000, 32'hE3A02007, 32'hE3A03001, 32'hE79B1101, 32'hE52D1004};
`else
    exp_w = '{32'hE3A01005, 32'hE52D1004, 32'hE3A01012, 32'hE3A02034, 32'hE1A01401, 32'hE1811002,
              32'hE52D1004, 32'hE320F000, 32'hE3A01000, 32'hE79B1101, 32'hE52D1004, 32'hE1A00000};
`endif
    test_reset();
    test_ff();
    test_stream();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/acc.md
ACC -- requirements
Module: acc

Interface
REQ-001 SHALL have parameter/constants: SMNL, 3, state width; PARAM_LEN, 2, operand-count width; adr_rom_adr_size, 8, link-list pointer width; FSTATE, 3'd7, final state code (all from me_consts.vh).
REQ-002 SHALL have one clock, clk; reset is asynchronous and active-low, port reset.
REQ-003 Ports: clk in 1 clock; reset in 1 async active-low reset; oram_ready in 1 output sink ready.
REQ-004 Ports: arm_inst out 32 emitted ARM word; valid_write out 1 arm_inst strobe; oram_iter out 8 emitted-word count.
REQ-005 Ports: state out SMNL FSM code; waiting out 1 stalled on sink; iram out 8 program byte at PC; iram_ready out 1 iram valid; jvm_opcode out 8 latched opcode.
REQ-006 Ports: parameter_number out PARAM_LEN operand bytes left; param_even out 1 even operand index; byte_to_push out 8 current operand; push_wide out 1 wide marker select; is_wide out 1 wide prefix seen.
REQ-007 Ports: q_select out 1 arm_inst source (0 instr, 1 push_inst); push_inst out 32 operand-load word; instr out 32 link-list ROM word; link_list_ptr out adr_rom_adr_size ROM pointer.

Function
REQ-008 Internal 256x8 program ROM (file jvm.hex), 256-entry start-pointer ROM by opcode (start.hex), 256-entry count ROM of operand bytes, link-list ROM of {instr[31:0], next ptr, last} (list.hex); all synchronous read, 1-cycle latency.
REQ-009 States: IDLE 0, FETCH 1, DECODE 2, PARAM 3, PUSH 4, EMIT 5, WAIT 6, FSTATE 7.
REQ-010 IDLE->FETCH next cycle after reset release; PC=0.
REQ-011 FETCH: iram_ready 1 cycle after PC change; opcode 0xFF -> FSTATE; 0xC4 -> set is_wide, PC+1, stay FETCH; else latch jvm_opcode, PC+1 -> DECODE.
REQ-012 DECODE: parameter_number=count ROM (doubled if is_wide); link_list_ptr=start ROM; ->PARAM if count>0 else EMIT.
REQ-013 PARAM: byte_to_push=iram, PC+1, ->PUSH.
REQ-014 PUSH: q_select=1; push_inst=0xE3A0_1000|byte (r1) when param_even, 0xE3A0_2000|byte (r2) otherwise; param_even starts 1 per opcode, toggles per byte; parameter_number decrements; ->PARAM while >0 else EMIT.
REQ-015 is_wide: one extra PUSH with push_wide=1, push_inst=0xE3A0_3001 (MOV r3,#1), before EMIT; is_wide clears after EMIT completes.
REQ-016 EMIT: q_select=0; arm_inst=instr; link_list_ptr follows next; last entry -> FETCH.
REQ-017 valid_write is a 1-cycle pulse per emitted word, only when oram_ready=1; if 0, enter WAIT, waiting=1, hold arm_inst, resume on oram_ready=1.
REQ-018 oram_iter increments per valid_write, wraps 255->0; PC wraps 255->0.
REQ-019 FSTATE absorbing; valid_write=0 there.
REQ-020 Sink partner (write): ready=1 idle, 0 for one cycle after start, then 1.

Reset
REQ-021 reset=0 asynchronously clears all regs: state=IDLE, PC, oram_iter, parameter_number, byte_to_push, jvm_opcode, link_list_ptr=0; all 1-bit outputs 0; arm_inst/push_inst=0.
REQ-022 Reset mid-translation discards partial opcode; restart from PC=0 after release.

Configuration
REQ-023 With WIDE_EN defined, REQ-011/012/015 wide handling is built in; without it 0xC4 is ordinary opcode (own count/list), is_wide and push_wide tie 0.

Verification
REQ-024 Program FF -> FSTATE within 4 cycles, no valid_write, oram_iter=0.
REQ-025 Program 10 05 FF -> E3A01005 then bipush list words, then FSTATE.
REQ-026 Program 11 12 34 FF -> E3A01012, E3A02034, then list for 0x11.
REQ-027 With WIDE_EN: C4 15 00 07 FF -> E3A01000, E3A02007, E3A03001, iload list; is_wide 0 afterward.
REQ-028 Hold oram_ready=0 5 cycles mid-EMIT -> waiting=1, arm_inst held, no valid_write; resumes with no loss/duplicate.
REQ-029 Assert reset=0 during PUSH -> outputs at reset values immediately; after release full output regenerated from PC=0.
